// File: rtl/keypad_scan_ctrl.sv
// Scans and debounces a 4x4 active-low matrix keypad and serves key codes over start_port/done_port.
// Optional KEYPAD_NONBLOCK_EN: a read with nothing pending completes at once with valid=0.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV_W   = 16,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_port,
  output logic       done_port,
  output logic [7:0] return_port,
  output logic [3:0] kp_col,
  input  logic [3:0] kp_row
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [3:0]            DEB     = 4'(DEBOUNCE_CNT);
  localparam logic [SCAN_DIV_W-1:0] DIV_ONE = SCAN_DIV_W'(1);

  state_t state_q, state_d;

  logic [3:0]            rowMeta_q, rowSync_q;
  logic [SCAN_DIV_W-1:0] div_q;
  logic [1:0]            colIdx_q;
  logic [15:0]           snapshot_q, prevSnapshot_q, stableMap_q;
  logic [3:0]            stableCnt_q;
  logic                  mapUpd_q;
  logic                  lastValid_q;
  logic [3:0]            lastKey_q;
  logic                  pending_q, ovf_q;
  logic [3:0]            code_q;
  logic [7:0]            ret_q;

  logic        tick, scanDone;
  logic [3:0]  rowsPressed;
  logic [15:0] newSnap;
  logic        keyFound;
  logic [3:0]  keyIdx;
  logic        keyEvent, consume;
  logic [7:0]  doneWord;

  assign tick        = &div_q;
  assign scanDone    = tick && (colIdx_q == 2'd3);
  assign rowsPressed = ~rowSync_q;
  assign consume     = (state_q == ST_DONE);
  assign kp_col      = ~(4'b0001 << colIdx_q);

  // Two-flop synchronizer; idles at all-released.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rowMeta_q <= 4'hF;
      rowSync_q <= 4'hF;
    end else begin
      rowMeta_q <= kp_row;
      rowSync_q <= rowMeta_q;
    end
  end

  // The completing scan is compared including the column being sampled right now.
  always_comb begin
    newSnap = snapshot_q;
    newSnap[{colIdx_q, 2'b00} +: 4] = rowsPressed;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q          <= '0;
      colIdx_q       <= 2'd0;
      snapshot_q     <= 16'h0;
      prevSnapshot_q <= 16'h0;
      stableCnt_q    <= 4'd0;
      stableMap_q    <= 16'h0;
      mapUpd_q       <= 1'b0;
    end else begin
      div_q    <= div_q + DIV_ONE;
      mapUpd_q <= 1'b0;
      if (tick) begin
        snapshot_q <= newSnap;
        colIdx_q   <= colIdx_q + 2'd1;
        if (scanDone) begin
          prevSnapshot_q <= newSnap;
          if (newSnap == prevSnapshot_q) begin
            if (stableCnt_q < DEB) stableCnt_q <= stableCnt_q + 4'd1;
            if (stableCnt_q == DEB - 4'd1) begin
              stableMap_q <= newSnap;
              mapUpd_q    <= 1'b1;
            end
          end else begin
            stableCnt_q <= 4'd0;
          end
        end
      end
    end
  end

  // Lowest pressed index wins when several keys are held.
  always_comb begin
    keyFound = 1'b0;
    keyIdx   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (stableMap_q[i]) begin
        keyFound = 1'b1;
        keyIdx   = 4'(i);
      end
    end
  end

  assign keyEvent = mapUpd_q && keyFound && (!lastValid_q || (keyIdx != lastKey_q));

  always_ff @(posedge clock) begin
    if (!reset) begin
      lastValid_q <= 1'b0;
      lastKey_q   <= 4'd0;
      pending_q   <= 1'b0;
      ovf_q       <= 1'b0;
      code_q      <= 4'd0;
      ret_q       <= 8'h00;
    end else begin
      if (mapUpd_q) begin
        lastValid_q <= keyFound;
        if (keyFound) lastKey_q <= keyIdx;
      end
      if (keyEvent) begin
        pending_q <= 1'b1;
        code_q    <= keyIdx;
        ovf_q     <= consume ? 1'b0 : (ovf_q | pending_q);
      end else if (consume) begin
        pending_q <= 1'b0;
        ovf_q     <= 1'b0;
      end
      if (consume) ret_q <= doneWord;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_port) begin
`ifdef KEYPAD_NONBLOCK_EN
          state_d = ST_DONE;
`else
          state_d = pending_q ? ST_DONE : ST_WAIT;
`endif
        end
      end
      ST_WAIT: if (pending_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // return_port shows the live word during DONE and holds it afterwards.
  always_comb begin
    doneWord    = {pending_q, ovf_q, 2'b00, pending_q ? code_q : 4'h0};
    done_port   = 1'b0;
    return_port = ret_q;
    if (state_q == ST_DONE) begin
      done_port   = 1'b1;
      return_port = doneWord;
    end
  end

endmodule
